memory_controller: RTL and testbench
====================================

Name: memory_controller

Overview:
- Single-clock, fully pipelined on-chip memory controller with independent write and read request ports.
- Accepts at most one write and one read per cycle, with no backpressure.
- Each accepted request returns a fixed-latency acknowledge carrying the request address; reads also return the data.
- Sits between a request generator (CPU/bench) and an internal word-addressed storage array.

Parameters:
- ADDR_W, 16, request/return address width.
- DATA_W, 16, data word width.
- MEM_AW, 10, storage index width; depth = 2**MEM_AW words; index = address[MEM_AW-1:0].
- WR_LAT, 2, cycles from the write-accept edge to wr_ret_ack high (>=1).
- RD_LAT, 4, cycles from the read-accept edge to rd_ret_ack high (>=1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- wr_address  in  ADDR_W  write address.
- wr_en  in  1  write request; sampled each rising edge.
- wr_data  in  DATA_W  write data.
- wr_ret_address  out  ADDR_W  address of the completing write.
- wr_ret_ack  out  1  one-cycle completion pulse per accepted write.
- rd_address  in  ADDR_W  read address.
- rd_en  in  1  read request; sampled each rising edge.
- rd_ret_data  out  DATA_W  read data.
- rd_ret_address  out  ADDR_W  address of the completing read.
- rd_ret_ack  out  1  one-cycle completion pulse per accepted read.

Behaviour:
- Reset: rst_n low at a rising edge clears both return pipelines. All outputs are 0 the following cycle: wr_ret_ack, rd_ret_ack, wr_ret_address, rd_ret_address and rd_ret_data.
- Reset mid-operation: in-flight requests are dropped and produce no ack. Requests presented while rst_n is low are ignored. Storage contents are not reset.
- Write accept: wr_en=1 at an edge (rst_n=1) writes wr_data to mem[wr_address[MEM_AW-1:0]] at that edge. wr_ret_ack=1 with wr_ret_address=wr_address exactly WR_LAT cycles later.
- Read accept: rd_en=1 at an edge samples mem[rd_address[MEM_AW-1:0]] at that edge. rd_ret_ack=1 with rd_ret_address=rd_address and the sampled data exactly RD_LAT cycles later.
- Throughput: one request per port per cycle. Back-to-back requests produce back-to-back acks in request order. No stalls.
- Address aliasing: upper address bits [ADDR_W-1:MEM_AW] are ignored for storage, but the full address is returned in the ret_address outputs.
- Same-cycle read and write to the same index: the read returns the old (pre-write) value (read-first).
- Read of an index written at any earlier edge returns the newest value.
- While an ack is 0, its ret_address output and rd_ret_data are driven 0.
- Read and write paths are independent; no ordering between their acks.

Optional Feature:
- Macro MC_ZERO_INIT_EN.
- Defined:
  - A per-word written bit (2**MEM_AW flops) is cleared by reset and set on write.
  - A read of a word whose bit is clear returns 0.
  - A write to an index clears nothing else.
- Undefined:
  - No written bits exist.
  - A read of a never-written word returns uninitialised storage (X in simulation).

Decomposition:
- Package memory_controller_pkg: default ADDR_W/DATA_W/MEM_AW/WR_LAT/RD_LAT localparams and a request struct {valid, addr, data}.
- Sub-module mc_delay_line: parameterised LAT-stage shift register of {valid, payload}, with synchronous active-low clear of the valid bits. Instantiated once for the write-ack path and once for the read-return path.
- Storage array and written bits live in memory_controller.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with wr_en=rd_en=1 -> no acks; all outputs 0 during reset and one cycle after release.
- Write stream: wr_address 150..155 with data 0..5, one per cycle -> wr_ret_ack pulses six consecutive cycles, WR_LAT after each accept, wr_ret_address 150..155.
- Read-back: after that stream, read 150..155 back-to-back -> rd_ret_ack for six consecutive cycles, RD_LAT after each accept; ret_address 150..155, ret_data 0..5.
- Unwritten read with MC_ZERO_INIT_EN: read addresses 0..5 after reset -> rd_ret_data=0, ret_address 0..5.
- Collision: same cycle, write 0xABCD to 0x20 and read 0x20, with old value 0x1111 -> read returns 0x1111; read of 0x20 next cycle returns 0xABCD.
- Aliasing and mid-flight reset:
  - Write 0x77 to 0x0005, then read 0x0405 (MEM_AW=10) -> data 0x77, rd_ret_address 0x0405.
  - Assert reset one cycle after a read accept -> that read produces no ack.

Source files
------------

// File: rtl/memory_controller_pkg.sv
// Shared defaults and request type for the memory controller.
// The optional written-bit feature is enabled by defining MC_ZERO_INIT_EN.
package memory_controller_pkg;

  localparam int MC_ADDR_W = 16;
  localparam int MC_DATA_W = 16;
  localparam int MC_MEM_AW = 10;
  localparam int MC_WR_LAT = 2;
  localparam int MC_RD_LAT = 4;

  typedef struct packed {
    logic                 valid;
    logic [MC_ADDR_W-1:0] addr;
    logic [MC_DATA_W-1:0] data;
  } mc_req_t;

endpackage

// File: rtl/mc_delay_line.sv
// LAT-stage shift register of {valid, payload}; the last stage is the registered output.
// Payload is forced to zero whenever valid is low, so idle outputs read as zero.
module mc_delay_line #(
  parameter int LAT = 2,
  parameter int PW  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [PW-1:0] in_payload,
  output logic          out_valid,
  output logic [PW-1:0] out_payload
);

  logic [LAT-1:0] valid_r;
  logic [PW-1:0]  payload_r [LAT];

  // shift stages, clearing the whole pipe on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        payload_r[i] <= {PW{1'b0}};
      end
    end else begin
      valid_r[0]   <= in_valid;
      payload_r[0] <= in_valid ? in_payload : {PW{1'b0}};
      for (int i = 1; i < LAT; i++) begin
        valid_r[i]   <= valid_r[i-1];
        payload_r[i] <= payload_r[i-1];
      end
    end
  end

  assign out_valid   = valid_r[LAT-1];
  assign out_payload = payload_r[LAT-1];

endmodule

// File: rtl/memory_controller.sv
// Fixed-latency pipelined memory controller with independent write and read ports.
// Define MC_ZERO_INIT_EN to make never-written words read back as zero.
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int ADDR_W = MC_ADDR_W,
  parameter int DATA_W = MC_DATA_W,
  parameter int MEM_AW = MC_MEM_AW,
  parameter int WR_LAT = MC_WR_LAT,
  parameter int RD_LAT = MC_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_ret_address,
  output logic              wr_ret_ack,
  input  logic [ADDR_W-1:0] rd_address,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_ret_data,
  output logic [ADDR_W-1:0] rd_ret_address,
  output logic              rd_ret_ack
);

  localparam int DEPTH = 1 << MEM_AW;

  logic [DATA_W-1:0] mem_r [DEPTH];
  mc_req_t           wr_req_s;
  mc_req_t           rd_req_s;
  logic [MEM_AW-1:0] wr_idx_s;
  logic [MEM_AW-1:0] rd_idx_s;

`ifdef MC_ZERO_INIT_EN
  logic [DEPTH-1:0] written_r;

  // track which words have ever been written since reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      written_r <= {DEPTH{1'b0}};
    end else if (wr_req_s.valid) begin
      written_r[wr_idx_s] <= 1'b1;
    end
  end
`endif

  // capture requests; anything presented during reset is dropped
  always_comb begin
    wr_req_s       = '{valid: 1'b0, addr: {ADDR_W{1'b0}}, data: {DATA_W{1'b0}}};
    rd_req_s       = '{valid: 1'b0, addr: {ADDR_W{1'b0}}, data: {DATA_W{1'b0}}};
    wr_req_s.valid = wr_en & rst_n;
    wr_req_s.addr  = wr_address;
    wr_req_s.data  = wr_data;
    wr_idx_s       = wr_address[MEM_AW-1:0];
    rd_idx_s       = rd_address[MEM_AW-1:0];
    rd_req_s.valid = rd_en & rst_n;
    rd_req_s.addr  = rd_address;
`ifdef MC_ZERO_INIT_EN
    rd_req_s.data  = written_r[rd_idx_s] ? mem_r[rd_idx_s] : {DATA_W{1'b0}};
`else
    rd_req_s.data  = mem_r[rd_idx_s];
`endif
  end

  // storage write; the read above sees the pre-write contents at the same edge
  always_ff @(posedge clk) begin
    if (wr_req_s.valid) begin
      mem_r[wr_idx_s] <= wr_req_s.data;
    end
  end

  mc_delay_line #(
    .LAT (WR_LAT),
    .PW  (ADDR_W)
  ) u_wr_ret (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (wr_req_s.valid),
    .in_payload  (wr_req_s.addr),
    .out_valid   (wr_ret_ack),
    .out_payload (wr_ret_address)
  );

  mc_delay_line #(
    .LAT (RD_LAT),
    .PW  (ADDR_W + DATA_W)
  ) u_rd_ret (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (rd_req_s.valid),
    .in_payload  ({rd_req_s.addr, rd_req_s.data}),
    .out_valid   (rd_ret_ack),
    .out_payload ({rd_ret_address, rd_ret_data})
  );

endmodule

// File: tb/tb_memory_controller.sv
// Self-checking bench for memory_controller: transaction-level model with due-cycle queues,
// plus literal pins on selected returns. Honours MC_ZERO_INIT_EN when defined.
module tb_memory_controller;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int MEM_AW = 10;
  localparam int WR_LAT = 2;
  localparam int RD_LAT = 4;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] wr_address;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] wr_ret_address;
  logic              wr_ret_ack;
  logic [ADDR_W-1:0] rd_address;
  logic              rd_en;
  logic [DATA_W-1:0] rd_ret_data;
  logic [ADDR_W-1:0] rd_ret_address;
  logic              rd_ret_ack;

  memory_controller #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .MEM_AW (MEM_AW),
    .WR_LAT (WR_LAT), .RD_LAT (RD_LAT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_address     (wr_address),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .wr_ret_address (wr_ret_address),
    .wr_ret_ack     (wr_ret_ack),
    .rd_address     (rd_address),
    .rd_en          (rd_en),
    .rd_ret_data    (rd_ret_data),
    .rd_ret_address (rd_ret_address),
    .rd_ret_ack     (rd_ret_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    logic [15:0] addr;
    logic [15:0] data;
    bit          dc;
  } ret_t;

  ret_t        wq[$];
  ret_t        rq[$];
  logic [15:0] mdl_mem [int];

  always @(posedge clk) begin
    ret_t e;
    int   idx;
    cyc++;
    if (!rst_n) begin
      wq.delete();
      rq.delete();
`ifdef MC_ZERO_INIT_EN
      mdl_mem.delete();
`endif
    end else begin
      if (rd_en) begin
        idx    = int'(rd_address) % (1 << MEM_AW);
        e.due  = cyc + RD_LAT - 1;
        e.addr = rd_address;
        if (mdl_mem.exists(idx)) begin
          e.data = mdl_mem[idx];
          e.dc   = 1'b0;
        end else begin
          e.data = 16'h0000;
`ifdef MC_ZERO_INIT_EN
          e.dc   = 1'b0;
`else
          e.dc   = 1'b1;
`endif
        end
        rq.push_back(e);
      end
      if (wr_en) begin
        idx          = int'(wr_address) % (1 << MEM_AW);
        mdl_mem[idx] = wr_data;
        e.due        = cyc + WR_LAT - 1;
        e.addr       = wr_address;
        e.data       = 16'h0000;
        e.dc         = 1'b0;
        wq.push_back(e);
      end
    end
  end

  // per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic [15:0] ew_addr, er_addr, er_data;
    logic        ew_ack, er_ack;
    bit          dc;
    if (chk_en) begin
      ew_ack = 1'b0; ew_addr = 16'h0000;
      er_ack = 1'b0; er_addr = 16'h0000; er_data = 16'h0000; dc = 1'b0;
      if (wq.size() > 0 && wq[0].due == cyc) begin
        ew_ack  = 1'b1;
        ew_addr = wq[0].addr;
        void'(wq.pop_front());
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        er_ack  = 1'b1;
        er_addr = rq[0].addr;
        er_data = rq[0].data;
        dc      = rq[0].dc;
        void'(rq.pop_front());
      end
      chk("wr_ret_ack", {31'd0, wr_ret_ack}, {31'd0, ew_ack});
      chk("wr_ret_address", {16'd0, wr_ret_address}, {16'd0, ew_addr});
      chk("rd_ret_ack", {31'd0, rd_ret_ack}, {31'd0, er_ack});
      chk("rd_ret_address", {16'd0, rd_ret_address}, {16'd0, er_addr});
      if (!dc) chk("rd_ret_data", {16'd0, rd_ret_data}, {16'd0, er_data});
    end
  end

  // ---------------- stimulus helpers (start and end at a negedge) ----------------
  task automatic step(input bit we, input logic [15:0] wa, input logic [15:0] wd,
                      input bit re, input logic [15:0] ra);
    wr_en = we; wr_address = wa; wr_data = wd;
    rd_en = re; rd_address = ra;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pin_rd(input string name, input logic [15:0] ra, input logic [15:0] exp);
    step(1'b0, 16'h0000, 16'h0000, 1'b1, ra);
    rd_en = 1'b0;
    repeat (RD_LAT - 1) @(negedge clk);
    #1;
    chk({name, "_ack"}, {31'd0, rd_ret_ack}, 32'd1);
    chk({name, "_addr"}, {16'd0, rd_ret_address}, {16'd0, ra});
    chk({name, "_data"}, {16'd0, rd_ret_data}, {16'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    // reset held 3 edges with both ports requesting
    rst_n = 1'b0; wr_en = 1'b1; wr_address = 16'h0020; wr_data = 16'h5555;
    rd_en = 1'b1; rd_address = 16'h0020;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    #1;
    chk("reset_wr_ack", {31'd0, wr_ret_ack}, 32'd0);
    chk("reset_rd_ack", {31'd0, rd_ret_ack}, 32'd0);
    chk("reset_rd_data", {16'd0, rd_ret_data}, 32'd0);
    idle(1);
    #1;
    chk("post_reset_rd_addr", {16'd0, rd_ret_address}, 32'd0);

    // reads of never-written words
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0000, 16'h0000, 1'b1, 16'(i));
    idle(RD_LAT + 1);
`ifdef MC_ZERO_INIT_EN
    pin_rd("zinit", 16'h0003, 16'h0000);
`endif

    // write stream 150..155, with a literal check of the first ack timing
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'(150 + i), 16'(i), 1'b0, 16'h0000);
      if (i == WR_LAT - 1) begin
        #1;
        chk("stream_first_wr_ack", {31'd0, wr_ret_ack}, 32'd1);
        chk("stream_first_wr_addr", {16'd0, wr_ret_address}, 32'd150);
      end
    end
    idle(WR_LAT + 1);

    // read-back 150..155
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0000, 16'h0000, 1'b1, 16'(150 + i));
    idle(RD_LAT + 1);
    pin_rd("readback_155", 16'd155, 16'h0005);

    // collision: read-first, then newest value
    step(1'b1, 16'h0020, 16'h1111, 1'b0, 16'h0000);
    idle(1);
    step(1'b1, 16'h0020, 16'hABCD, 1'b1, 16'h0020);
    wr_en = 1'b0;
    @(negedge clk);
    rd_en = 1'b0;
    repeat (RD_LAT - 2) @(negedge clk);
    #1;
    chk("collision_old", {16'd0, rd_ret_data}, 32'h1111);
    @(negedge clk);
    #1;
    chk("collision_new", {16'd0, rd_ret_data}, 32'hABCD);
    idle(RD_LAT);

    // address aliasing
    step(1'b1, 16'h0005, 16'h0077, 1'b0, 16'h0000);
    idle(1);
    pin_rd("alias", 16'h0405, 16'h0077);
    idle(2);

    // reset one cycle after a read accept; write during reset must be ignored
    step(1'b0, 16'h0000, 16'h0000, 1'b1, 16'd150);
    rst_n = 1'b0;
    step(1'b1, 16'd151, 16'hDEAD, 1'b0, 16'h0000);
    rst_n = 1'b1;
    wr_en = 1'b0;
    acks = 0;
    for (int i = 0; i < RD_LAT + 2; i++) begin
      @(negedge clk);
      #1;
      if (rd_ret_ack) acks++;
    end
    chk("midflight_rd_acks", 32'(acks), 32'd0);
`ifdef MC_ZERO_INIT_EN
    pin_rd("after_reset_151", 16'd151, 16'h0000);
`else
    pin_rd("after_reset_151", 16'd151, 16'h0001);
`endif
    idle(2);

    // mixed concurrent traffic on both ports
    for (int i = 0; i < 32; i++) begin
      step((i % 3) != 0, 16'h0100 + 16'(i % 8) + ((i % 2 == 1) ? 16'h0400 : 16'h0000),
           16'(i * 16'h0111), (i % 2 == 0) || (i > 20), 16'h0100 + 16'((i + 3) % 8));
    end
    idle(RD_LAT + 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
